// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// fetch stage (instruction reads) and the memory stage (loads/stores).
// Data requests have fixed priority; one access occupies LATENCY+2 cycles.
// Optional build macro MEMARB_ALIGN_CHK_EN: odd grant addresses pulse err and
// the access proceeds with ram_addr[0] forced to 0.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  output logic [15:0] mem_rdata,
  output logic        mem_valid,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;      // 1 = data stage, 0 = fetch
  logic        flush_q, flush_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_wr_q, ram_wr_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        mem_valid_q, mem_valid_d;
  logic        err_q, err_d;

  logic        mem_req;
  logic [15:0] raw_addr;
  logic [15:0] grant_addr;
  logic        odd_err;

  assign mem_req = mem_rd | mem_wr;

  // Select the address of the requester that would win a grant, with optional alignment check.
  always_comb begin
    raw_addr   = mem_req ? mem_addr : if_addr;
    grant_addr = raw_addr;
`ifdef MEMARB_ALIGN_CHK_EN
    odd_err       = raw_addr[0];
    grant_addr[0] = 1'b0;
`else
    odd_err       = 1'b0;
`endif
  end

  // Next-state and next-output computation for the IDLE/BUSY/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    flush_d     = flush_q;
    ram_en_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req || if_req) begin
          owner_d     = mem_req;
          flush_d     = 1'b0;
          ram_en_d    = 1'b1;
          ram_wr_d    = mem_req & mem_wr;
          ram_addr_d  = grant_addr;
          ram_wdata_d = mem_wdata;
          cnt_d       = 4'(LATENCY);
          err_d       = (mem_rd & mem_wr) | odd_err;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (!owner_q && if_flush) flush_d = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          if (owner_q) begin
            mem_rdata_d = ram_rdata;
            mem_valid_d = 1'b1;
          end else begin
            if_rdata_d = ram_rdata;
            if_valid_d = ~flush_d;
          end
        end
      end
      RESP: begin
        if (!owner_q && if_flush) flush_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      flush_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      flush_q     <= flush_d;
      ram_en_q    <= ram_en_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      err_q       <= err_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_valid = mem_valid_q;
  assign err       = err_q;
  // A flush arriving in the RESP cycle itself must still suppress the fetch valid.
  assign if_valid  = if_valid_q & ~if_flush;
  assign if_stall  = rst & if_req & ~if_valid;
  assign mem_stall = rst & mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a fixed-latency memory model
// and per-requester response scoreboards.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [15:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic        ram_en, ram_wr, if_valid, mem_valid, if_stall, mem_stall, err;
  logic [15:0] ram_addr, ram_wdata, if_rdata, mem_rdata;
  logic [15:0] ram_rdata = 16'hDEAD;

  mem_port_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .if_stall(if_stall), .mem_stall(mem_stall), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    bit          chk;
  } exp_t;
  exp_t exp_if[$];
  exp_t exp_mem[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: data for an access enabled in cycle E is presented in cycle E+LAT-1.
  logic [15:0] mem [0:255];
  logic [7:0]  rd_idx = '0;
  int          data_cyc = -100;
  always @(negedge clk) begin
    if (ram_en === 1'b1) begin
      if (ram_wr === 1'b1) mem[ram_addr[7:0]] = ram_wdata;
      rd_idx   = ram_addr[7:0];
      data_cyc = cyc + int'(LAT) - 1;
    end
    ram_rdata = (cyc == data_cyc) ? mem[rd_idx] : 16'hDEAD;
  end

  task automatic at_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; if_req = 1'b1; mem_rd = 1'b1; mem_addr = 16'h0010; if_addr = 16'h0004;
    repeat (3) at_edge();
    mid();
    n_checks++;
    if ({ram_en, ram_wr, ram_addr, ram_wdata, if_rdata, if_valid, mem_rdata, mem_valid,
         if_stall, mem_stall, err} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0", {ram_en, ram_wr, ram_addr, ram_wdata,
               if_rdata, if_valid, mem_rdata, mem_valid, if_stall, mem_stall, err});
    end
    if_req = 1'b0; mem_rd = 1'b0;
    at_edge();
    rst = 1'b1;
    at_edge();
  endtask

  task automatic test_load;
    int t0; bit seen; exp_t e;
    seen = 0;
    at_edge(); t0 = cyc;
    mem_rd = 1'b1; mem_addr = 16'h0010;
    exp_mem.push_back('{t0 + 5, 16'hBEEF, 1'b1});
    for (int k = 0; k < 10; k++) begin
      mid();
      n_checks++;
      if (ram_en !== (k == 1) || mem_valid !== (k == 5) || mem_stall !== (k <= 4)) begin
        n_fail++;
        $display("FAIL load_timing k=%0d got en/valid/stall %b%b%b required %b%b%b", k,
                 ram_en, mem_valid, mem_stall, k == 1, k == 5, k <= 4);
      end
      if (k == 1) begin
        n_checks++;
        if (ram_addr !== 16'h0010 || ram_wr !== 1'b0) begin
          n_fail++;
          $display("FAIL load_port got addr %h wr %b required 0010 0", ram_addr, ram_wr);
        end
      end
      if (mem_valid === 1'b1) begin
        n_checks++;
        if (exp_mem.size() == 0) begin
          n_fail++; $display("FAIL load_resp unexpected valid at cycle %0d", cyc);
        end else begin
          e = exp_mem.pop_front();
          if (cyc != e.cyc || (e.chk && mem_rdata !== e.data)) begin
            n_fail++;
            $display("FAIL load_resp got cycle %0d data %h required cycle %0d data %h",
                     cyc, mem_rdata, e.cyc, e.data);
          end
        end
        seen = 1;
      end
      at_edge();
      if (seen) mem_rd = 1'b0;
    end
    n_checks++;
    if (exp_mem.size() != 0) begin
      n_fail++; $display("FAIL load_missing got %0d pending required 0", exp_mem.size());
      exp_mem.delete();
    end
  endtask

  task automatic test_priority;
    int t0; exp_t e;
    at_edge(); t0 = cyc;
    mem_wr = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h1234;
    if_req = 1'b1; if_addr = 16'h0030;
    exp_mem.push_back('{t0 + 5, 16'h0000, 1'b0});
    exp_if.push_back('{t0 + 11, 16'h5A30, 1'b1});
    for (int k = 0; k < 14; k++) begin
      mid();
      n_checks++;
      if (ram_en !== (k == 1 || k == 7) || mem_valid !== (k == 5) || if_valid !== (k == 11) ||
          mem_stall !== (k <= 4) || if_stall !== (k <= 10)) begin
        n_fail++;
        $display("FAIL prio_timing k=%0d got en/mv/iv/ms/is %b%b%b%b%b", k,
                 ram_en, mem_valid, if_valid, mem_stall, if_stall);
      end
      if (k == 1) begin
        n_checks++;
        if (ram_wr !== 1'b1 || ram_addr !== 16'h0020 || ram_wdata !== 16'h1234) begin
          n_fail++;
          $display("FAIL prio_store_port got wr %b addr %h wdata %h required 1 0020 1234",
                   ram_wr, ram_addr, ram_wdata);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (ram_wr !== 1'b0 || ram_addr !== 16'h0030) begin
          n_fail++;
          $display("FAIL prio_fetch_port got wr %b addr %h required 0 0030", ram_wr, ram_addr);
        end
      end
      if (mem_valid === 1'b1 && exp_mem.size() != 0) begin
        e = exp_mem.pop_front();
        n_checks++;
        if (cyc != e.cyc) begin
          n_fail++; $display("FAIL prio_store_resp got cycle %0d required %0d", cyc, e.cyc);
        end
      end
      if (if_valid === 1'b1 && exp_if.size() != 0) begin
        e = exp_if.pop_front();
        n_checks++;
        if (cyc != e.cyc || if_rdata !== e.data) begin
          n_fail++;
          $display("FAIL prio_fetch_resp got cycle %0d data %h required cycle %0d data %h",
                   cyc, if_rdata, e.cyc, e.data);
        end
      end
      at_edge();
      if (k == 5) mem_wr = 1'b0;
      if (k == 11) if_req = 1'b0;
    end
    n_checks++;
    if (exp_mem.size() != 0 || exp_if.size() != 0) begin
      n_fail++;
      $display("FAIL prio_missing got %0d/%0d pending required 0", exp_mem.size(), exp_if.size());
      exp_mem.delete(); exp_if.delete();
    end
  endtask

  task automatic test_flush;
    int t0; int fl_at[3]; int drop_at[3]; bit want_v; bit want_s; exp_t e;
    fl_at   = '{2, 0, 5};
    drop_at = '{3, 6, 6};
    for (int ph = 0; ph < 3; ph++) begin
      at_edge(); t0 = cyc;
      if_req = 1'b1; if_addr = 16'h0040 + 16'(2 * ph);
      if (ph == 1) exp_if.push_back('{t0 + 5, 16'h5A42, 1'b1});
      for (int k = 0; k < 8; k++) begin
        if (k == fl_at[ph]) if_flush = 1'b1;
        mid();
        want_v = (ph == 1) && (k == 5);
        want_s = (k < drop_at[ph]) && !want_v;
        n_checks++;
        if (ram_en !== (k == 1) || if_valid !== want_v || if_stall !== want_s) begin
          n_fail++;
          $display("FAIL flush_ph%0d k=%0d got en/valid/stall %b%b%b required %b%b%b", ph, k,
                   ram_en, if_valid, if_stall, k == 1, want_v, want_s);
        end
        if (if_valid === 1'b1 && exp_if.size() != 0) begin
          e = exp_if.pop_front();
          n_checks++;
          if (cyc != e.cyc || if_rdata !== e.data) begin
            n_fail++;
            $display("FAIL flush_resp got cycle %0d data %h required cycle %0d data %h",
                     cyc, if_rdata, e.cyc, e.data);
          end
        end
        at_edge();
        if_flush = 1'b0;
        if (k + 1 == drop_at[ph]) if_req = 1'b0;
      end
      n_checks++;
      if (exp_if.size() != 0) begin
        n_fail++; $display("FAIL flush_missing got %0d pending required 0", exp_if.size());
        exp_if.delete();
      end
    end
  endtask

  task automatic test_rdwr_err;
    int t0;
    at_edge(); t0 = cyc;
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0050; mem_wdata = 16'h7777;
    for (int k = 0; k < 8; k++) begin
      mid();
      n_checks++;
      if (ram_en !== (k == 1) || err !== (k == 1) || mem_valid !== (k == 5)) begin
        n_fail++;
        $display("FAIL rdwr_timing k=%0d got en/err/valid %b%b%b required %b%b%b", k,
                 ram_en, err, mem_valid, k == 1, k == 1, k == 5);
      end
      if (k == 1) begin
        n_checks++;
        if (ram_wr !== 1'b1 || ram_addr !== 16'h0050 || ram_wdata !== 16'h7777) begin
          n_fail++;
          $display("FAIL rdwr_port got wr %b addr %h wdata %h required 1 0050 7777",
                   ram_wr, ram_addr, ram_wdata);
        end
      end
      at_edge();
      if (k == 5) begin mem_rd = 1'b0; mem_wr = 1'b0; end
    end
  endtask

  task automatic test_align;
    int t0; bit want_err; logic [15:0] want_addr; exp_t e;
`ifdef MEMARB_ALIGN_CHK_EN
    want_err = 1'b1; want_addr = 16'h0012;
`else
    want_err = 1'b0; want_addr = 16'h0013;
`endif
    at_edge(); t0 = cyc;
    mem_rd = 1'b1; mem_addr = 16'h0013;
    exp_mem.push_back('{t0 + 5, 16'h5A00 | want_addr, 1'b1});
    for (int k = 0; k < 8; k++) begin
      mid();
      n_checks++;
      if (err !== (want_err && k == 1)) begin
        n_fail++; $display("FAIL align_err k=%0d got %b required %b", k, err, want_err && k == 1);
      end
      if (k == 1) begin
        n_checks++;
        if (ram_addr !== want_addr) begin
          n_fail++; $display("FAIL align_addr got %h required %h", ram_addr, want_addr);
        end
      end
      if (mem_valid === 1'b1 && exp_mem.size() != 0) begin
        e = exp_mem.pop_front();
        n_checks++;
        if (cyc != e.cyc || mem_rdata !== e.data) begin
          n_fail++;
          $display("FAIL align_resp got cycle %0d data %h required cycle %0d data %h",
                   cyc, mem_rdata, e.cyc, e.data);
        end
      end
      at_edge();
      if (k == 5) mem_rd = 1'b0;
    end
    n_checks++;
    if (exp_mem.size() != 0) begin
      n_fail++; $display("FAIL align_missing got %0d pending required 0", exp_mem.size());
      exp_mem.delete();
    end
  endtask

  task automatic test_reset_mid;
    int t1; exp_t e;
    at_edge();
    mem_rd = 1'b1; mem_addr = 16'h0010;
    for (int k = 0; k < 2; k++) begin
      mid();
      n_checks++;
      if (ram_en !== (k == 1)) begin
        n_fail++; $display("FAIL rstmid_en k=%0d got %b required %b", k, ram_en, k == 1);
      end
      at_edge();
    end
    mid();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ram_en, ram_wr, ram_addr, ram_wdata, if_rdata, if_valid, mem_rdata, mem_valid,
         if_stall, mem_stall, err} !== 71'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got %h required 0", {ram_en, ram_wr, ram_addr, ram_wdata,
               if_rdata, if_valid, mem_rdata, mem_valid, if_stall, mem_stall, err});
    end
    at_edge(); at_edge();
    mem_rd = 1'b0; rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mid();
      n_checks++;
      if (ram_en !== 1'b0 || mem_valid !== 1'b0 || if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_quiet k=%0d got en/mv/iv %b%b%b required 000", k,
                 ram_en, mem_valid, if_valid);
      end
      at_edge();
    end
    t1 = cyc;
    mem_rd = 1'b1; mem_addr = 16'h0020;
    exp_mem.push_back('{t1 + 5, 16'h1234, 1'b1});
    for (int k = 0; k < 8; k++) begin
      mid();
      n_checks++;
      if (ram_en !== (k == 1) || mem_valid !== (k == 5)) begin
        n_fail++;
        $display("FAIL rstmid_after k=%0d got en/valid %b%b required %b%b", k,
                 ram_en, mem_valid, k == 1, k == 5);
      end
      if (mem_valid === 1'b1 && exp_mem.size() != 0) begin
        e = exp_mem.pop_front();
        n_checks++;
        if (cyc != e.cyc || mem_rdata !== e.data) begin
          n_fail++;
          $display("FAIL rstmid_resp got cycle %0d data %h required cycle %0d data %h",
                   cyc, mem_rdata, e.cyc, e.data);
        end
      end
      at_edge();
      if (k == 5) mem_rd = 1'b0;
    end
    n_checks++;
    if (exp_mem.size() != 0) begin
      n_fail++; $display("FAIL rstmid_missing got %0d pending required 0", exp_mem.size());
      exp_mem.delete();
    end
  endtask

  task automatic test_back_to_back;
    int t0; exp_t e;
    at_edge(); t0 = cyc;
    mem_rd = 1'b1; mem_addr = 16'h0020;
    if_req = 1'b1; if_addr = 16'h0044;
    exp_mem.push_back('{t0 + 5, 16'h1234, 1'b1});
    exp_mem.push_back('{t0 + 11, 16'h7777, 1'b1});
    exp_if.push_back('{t0 + 17, 16'h5A44, 1'b1});
    for (int k = 0; k < 20; k++) begin
      mid();
      n_checks++;
      if (ram_en !== (k == 1 || k == 7 || k == 13) || mem_valid !== (k == 5 || k == 11) ||
          if_valid !== (k == 17) || mem_stall !== (k <= 10 && k != 5) || if_stall !== (k <= 16)) begin
        n_fail++;
        $display("FAIL b2b_timing k=%0d got en/mv/iv/ms/is %b%b%b%b%b", k,
                 ram_en, mem_valid, if_valid, mem_stall, if_stall);
      end
      if (k == 7) begin
        n_checks++;
        if (ram_addr !== 16'h0050) begin
          n_fail++; $display("FAIL b2b_addr got %h required 0050", ram_addr);
        end
      end
      if (mem_valid === 1'b1 && exp_mem.size() != 0) begin
        e = exp_mem.pop_front();
        n_checks++;
        if (cyc != e.cyc || mem_rdata !== e.data) begin
          n_fail++;
          $display("FAIL b2b_load_resp got cycle %0d data %h required cycle %0d data %h",
                   cyc, mem_rdata, e.cyc, e.data);
        end
      end
      if (if_valid === 1'b1 && exp_if.size() != 0) begin
        e = exp_if.pop_front();
        n_checks++;
        if (cyc != e.cyc || if_rdata !== e.data) begin
          n_fail++;
          $display("FAIL b2b_fetch_resp got cycle %0d data %h required cycle %0d data %h",
                   cyc, if_rdata, e.cyc, e.data);
        end
      end
      at_edge();
      if (k == 5) mem_addr = 16'h0050;
      if (k == 11) mem_rd = 1'b0;
      if (k == 17) if_req = 1'b0;
    end
    n_checks++;
    if (exp_mem.size() != 0 || exp_if.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing got %0d/%0d pending required 0", exp_mem.size(), exp_if.size());
      exp_mem.delete(); exp_if.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
    mem[8'h10] = 16'hBEEF;
    test_reset();
    test_load();
    test_priority();
    test_flush();
    test_rdwr_err();
    test_align();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
